// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI slave port.
// Optional feature macro: SPI_SLAVE_PARITY_EN (adds an even-parity bit after the payload).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    WAIT_HIGH
  } spi_state_t;

  localparam int SPI_DATALEN = 64;

`ifdef SPI_SLAVE_PARITY_EN
  localparam int SPI_PARITY_BITS = 1;
`else
  localparam int SPI_PARITY_BITS = 0;
`endif

  function automatic int spi_frame_bits(input int datalen);
    return datalen + SPI_PARITY_BITS;
  endfunction

  function automatic int spi_cnt_width(input int nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// LSB-first shift register with parallel load; load has priority over shift.
// o_next is the value the register takes on a shift, so callers can use a completed word without waiting a cycle.
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_shift_in,
  output logic [WIDTH-1:0] o_next,
  output logic             o_lsb
);

  logic [WIDTH-1:0] r_data;

  assign o_next = {i_shift_in, r_data[WIDTH-1:1]};
  assign o_lsb  = r_data[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= o_next;
    end
  end

endmodule

// File: rtl/spi_slave_port.sv
// Same-clock SPI slave endpoint: receives LSB-first frames on MOSI, returns a buffered word on MISO.
// Optional feature macro: SPI_SLAVE_PARITY_EN (even parity bit appended to both directions).
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int DATALEN = SPI_DATALEN
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [DATALEN-1:0] txData,
  input  logic               txValid,
  output logic               txReady,
  output logic [DATALEN-1:0] rxData,
  output logic               rxValid,
  input  logic               rxReady,
  output logic               frameErr,
  output logic               overrun
);

  localparam int NBITS = spi_frame_bits(DATALEN);
  localparam int CW    = spi_cnt_width(NBITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  spi_state_t         r_state;
  logic [CW-1:0]      r_count;
  logic [DATALEN-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_tx_full;
  logic               r_frame_err;
  logic               r_overrun;

  logic               w_in_frame;
  logic               w_sample;
  logic               w_abort;
  logic               w_last;
  logic               w_accept;
  logic               w_par_ok;
  logic               w_tx_load;
  logic [NBITS-1:0]   w_rx_next;
  logic [NBITS-1:0]   w_tx_load_word;
  logic               w_tx_lsb;
  logic               w_rx_unused_lsb;
  logic [NBITS-1:0]   w_tx_unused_next;

  assign w_in_frame = (r_state == START) || (r_state == SHIFT);
  assign w_sample   = w_in_frame && !SS_n;
  assign w_abort    = w_in_frame && SS_n;
  // START always samples bit 0, so only SHIFT can hold the final bit.
  assign w_last     = w_sample && (r_state == SHIFT) && (r_count == LAST_CNT);
  assign w_accept   = !r_rx_valid || rxReady;
  assign w_tx_load  = txValid && txReady;

`ifdef SPI_SLAVE_PARITY_EN
  assign w_par_ok       = ((^w_rx_next[DATALEN-1:0]) == w_rx_next[DATALEN]);
  assign w_tx_load_word = {^txData, txData};
`else
  assign w_par_ok       = 1'b1;
  assign w_tx_load_word = txData;
`endif

  spi_shift_reg #(.WIDTH(NBITS)) u_rx_shift (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_load      (w_abort),
    .i_load_data ('0),
    .i_shift     (w_sample),
    .i_shift_in  (MOSI),
    .o_next      (w_rx_next),
    .o_lsb       (w_rx_unused_lsb)
  );

  spi_shift_reg #(.WIDTH(NBITS)) u_tx_shift (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_load      (w_tx_load),
    .i_load_data (w_tx_load_word),
    .i_shift     (w_sample),
    .i_shift_in  (1'b0),
    .o_next      (w_tx_unused_next),
    .o_lsb       (w_tx_lsb)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_full   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_rx_valid && rxReady) begin
        r_rx_valid <= 1'b0;
      end
      if (w_tx_load) begin
        r_tx_full <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          r_count <= '0;
          if (!SS_n) begin
            r_state <= START;
          end
        end
        START, SHIFT: begin
          if (SS_n) begin
            r_frame_err <= 1'b1;
            r_tx_full   <= 1'b0;
            r_count     <= '0;
            r_state     <= IDLE;
          end else if (w_last) begin
            r_count   <= '0;
            r_tx_full <= 1'b0;
            r_state   <= WAIT_HIGH;
            // A completed frame overrides the consume-clear above.
            if (!w_par_ok) begin
              r_frame_err <= 1'b1;
            end else if (w_accept) begin
              r_rx_data  <= w_rx_next[DATALEN-1:0];
              r_rx_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_count <= r_count + CW'(1);
            r_state <= SHIFT;
          end
        end
        WAIT_HIGH: begin
          if (SS_n) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MISO     = (!SS_n && r_tx_full) ? w_tx_lsb : 1'b0;
  assign txReady  = (r_state == IDLE) && !r_tx_full;
  assign rxData   = r_rx_data;
  assign rxValid  = r_rx_valid;
  assign frameErr = r_frame_err;
  assign overrun  = r_overrun;

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- Peripheral-side endpoint directly downstream of the single-master SPI block.
- Consumes SS_n/MOSI, assembles received frames, and presents them to local logic over a valid/ready handshake.
- Simultaneously serialises a locally supplied word onto MISO.
- Same clock domain as the master; one bit per clock while selected, no separate serial clock.

Parameters:
- DATALEN, 64, frame payload width in bits; must be ≥ 2.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- SS_n  input  1  slave select from master, active low.
- MOSI  input  1  serial data from master, LSB first.
- MISO  output  1  serial data to master, LSB first.
- txData  input  DATALEN  word to return on the next frame.
- txValid  input  1  txData offered.
- txReady  output  1  tx buffer empty and not mid-frame.
- rxData  output  DATALEN  last complete received frame.
- rxValid  output  1  rxData holds an unconsumed frame.
- rxReady  input  1  local logic accepts rxData.
- frameErr  output  1  one-cycle pulse: SS_n released mid-frame.
- overrun  output  1  one-cycle pulse: frame arrived while rxValid was still high.

Behaviour:
- Interface: one clock, asynchronous active-low reset; ports named clock and reset_n.
- Reset values:
  - State IDLE; bit counter 0; rx/tx shift registers 0; tx buffer empty.
  - rxData=0; rxValid=0; txReady=1; MISO=0; frameErr=0; overrun=0.
- States: IDLE, START, SHIFT, WAIT_HIGH (enum in package).
- IDLE: SS_n=0 at an edge -> START. No data sampled on this edge; this is the master's select/preamble cycle.
- START -> SHIFT unconditionally if SS_n still 0.
  - The START edge samples bit 0.
  - SHIFT samples bits 1..DATALEN-1, one per edge.
  - Counter width $clog2(DATALEN+1).
- Sampling: rxShift <= {MOSI, rxShift[DATALEN-1:1]}.
- Final bit (count reaches DATALEN):
  - If rxValid==0 or rxReady==1 that cycle: rxData <= assembled word, rxValid<=1. Visible the cycle after the last sample edge (zero extra latency).
  - Otherwise: old rxData kept, new frame dropped, overrun pulses 1 cycle.
  - State -> WAIT_HIGH if SS_n still 0, else IDLE.
- WAIT_HIGH: further MOSI bits ignored; -> IDLE on SS_n=1.
- SS_n=1 while in START/SHIFT with count < DATALEN:
  - frameErr pulses 1 cycle; partial word discarded; tx word discarded; -> IDLE.
- rxValid clears on an edge with rxValid&&rxReady unless a new frame loads the same edge (then stays 1 with new data).
- TX path:
  - txReady = (state==IDLE) && tx buffer empty.
  - txValid&&txReady at an edge loads txShift, marks buffer full.
  - MISO = txShift[0] when SS_n==0 and buffer full, else 0.
  - txShift >>1 on every sampling edge.
  - Buffer empties at frame end or abort.
  - Frame with empty buffer returns all zeros.
- Reset mid-frame: immediate return to reset values; no error pulse.

Optional Feature:
- Macro: SPI_SLAVE_PARITY_EN.
- Defined:
  - Frame is DATALEN+1 bits; the extra last bit is even parity over the payload.
  - Mismatch: rxValid not set, frameErr pulses at frame end.
  - MISO appends even parity of the tx word as bit DATALEN.
  - Counter sized for DATALEN+1.
- Undefined: no parity bit; behaviour exactly as above.

Decomposition:
- Package spi_pkg:
  - spi_state_t enum {IDLE, START, SHIFT, WAIT_HIGH}.
  - SPI_DATALEN default constant (64).
  - Counter-width function.
- One sub-module: spi_shift_reg, parameterised width, LSB-first, with load/shift enables. Instantiated twice (rx and tx).

Test Plan (DATALEN=8):
- Frame: SS_n low 9 cycles, MOSI LSB-first for 0xA5 -> rxData=0xA5, rxValid=1 after 9th edge; frameErr=0.
- txData=0x3C loaded in IDLE, then frame -> MISO bits 0,0,1,1,1,1,0,0 on successive sample cycles; txReady=0 until frame end, then 1.
- SS_n raised after 4 bits -> frameErr single-cycle pulse; rxValid stays 0; next full frame 0x11 received correctly.
- Two frames 0x01, 0x02, rxReady held 0 -> rxData stays 0x01, overrun pulses once at end of second frame; rxReady=1 then clears rxValid.
- SS_n held low 20 cycles -> one frame captured, remaining bits ignored; reset_n pulsed mid-frame -> all outputs return to reset values asynchronously.
- With SPI_SLAVE_PARITY_EN: 0x07 plus parity 1 -> rxValid=1; parity 0 -> frameErr pulse, rxValid=0.
